// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM pipeline stage: funct3 load/store codes,
// MEM FSM state encodings and the access-alignment helper.
package mem_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_REQ  = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    // funct3[1:0] carries the access size for both loads and stores.
    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addr);
        logic result;
        case (funct3[1:0])
            2'b01:   result = addr[0];
            2'b10:   result = (addr != 2'b00);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Formats an aligned 32-bit cache word into the load result selected by
// funct3 and the low address bits.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = rdata_i[{addr_i, 3'b000} +: 8];
        halfSel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byteSel[7]}}, byteSel};
            F3_LH:   data_o = {{16{halfSel[15]}}, halfSel};
            F3_LW:   data_o = rdata_i;
            F3_LBU:  data_o = {24'h000000, byteSel};
            F3_LHU:  data_o = {16'h0000, halfSel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers, D-cache request/response
// sequencing, load formatting and upstream stall generation.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int N     = 32,
    parameter int REG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [N-1:0]     ex_alu_out,
    input  logic [N-1:0]     ex_store_data,
    input  logic [2:0]       ex_funct3,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             flush,
    output logic             stall_out,
    output logic             dc_req_valid,
    output logic             dc_req_we,
    output logic [N-1:0]     dc_req_addr,
    output logic [N-1:0]     dc_req_wdata,
    output logic [3:0]       dc_req_be,
    input  logic             dc_req_ready,
    input  logic             dc_resp_valid,
    input  logic [N-1:0]     dc_resp_rdata,
    output logic             wb_valid,
    output logic [N-1:0]     wb_result,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_reg_write,
    output logic             misalign_exc
);

    logic             exmValid_q;
    logic [N-1:0]     exmAlu_q;
    logic [N-1:0]     exmStoreData_q;
    logic [2:0]       exmFunct3_q;
    logic             exmMemRead_q;
    logic             exmMemWrite_q;
    logic             exmRegWrite_q;
    logic [REG_W-1:0] exmRd_q;

    logic [1:0]       state_q, state_d;
    logic             wbValid_q, wbValid_d;
    logic [N-1:0]     wbResult_q, wbResult_d;
    logic [REG_W-1:0] wbRd_q, wbRd_d;
    logic             wbRegWrite_q, wbRegWrite_d;
    logic             misalign_q;

    logic             isLoad, isStore, misalign, memOp;
    logic [N-1:0]     loadData;

    // Both read and write set is illegal and is handled as a load.
    assign isLoad   = exmMemRead_q;
    assign isStore  = exmMemWrite_q & ~exmMemRead_q;
    assign misalign = exmValid_q & (isLoad | isStore) & isMisaligned(exmFunct3_q, exmAlu_q[1:0]);
    assign memOp    = exmValid_q & (isLoad | isStore) & ~misalign;

    load_align u_load_align (
        .rdata_i  (dc_resp_rdata),
        .addr_i   (exmAlu_q[1:0]),
        .funct3_i (exmFunct3_q),
        .data_o   (loadData)
    );

    always_comb begin
        stall_out    = 1'b0;
        dc_req_valid = 1'b0;
        state_d      = state_q;
        case (state_q)
            MEM_IDLE, MEM_REQ: begin
                dc_req_valid = memOp;
                stall_out    = memOp & ~(dc_req_ready & isStore);
                if (memOp) begin
                    if (!dc_req_ready)  state_d = MEM_REQ;
                    else if (isLoad)    state_d = MEM_WAIT;
                    else                state_d = MEM_IDLE;
                end
            end
            MEM_WAIT: begin
                stall_out = memOp & ~dc_resp_valid;
                if (dc_resp_valid) state_d = MEM_IDLE;
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_comb begin
        dc_req_we   = isStore;
        dc_req_addr = {exmAlu_q[N-1:2], 2'b00};
        case (exmFunct3_q[1:0])
            2'b00:   dc_req_wdata = {4{exmStoreData_q[7:0]}};
            2'b01:   dc_req_wdata = {2{exmStoreData_q[15:0]}};
            default: dc_req_wdata = exmStoreData_q;
        endcase
        dc_req_be = 4'b0000;
        if (isStore) begin
            case (exmFunct3_q[1:0])
                2'b00:   dc_req_be = 4'b0001 << exmAlu_q[1:0];
                2'b01:   dc_req_be = 4'b0011 << exmAlu_q[1:0];
                default: dc_req_be = 4'b1111;
            endcase
        end
    end

    // A non-stalled valid aligned entry retires this cycle; anything else is a bubble.
    always_comb begin
        wbValid_d    = 1'b0;
        wbRegWrite_d = 1'b0;
        wbResult_d   = wbResult_q;
        wbRd_d       = wbRd_q;
        if (!stall_out && exmValid_q && !misalign) begin
            wbValid_d = 1'b1;
            wbRd_d    = exmRd_q;
            if (isLoad) begin
                wbResult_d   = loadData;
                wbRegWrite_d = exmRegWrite_q;
            end else if (isStore) begin
                wbResult_d   = exmAlu_q;
            end else begin
                wbResult_d   = exmAlu_q;
                wbRegWrite_d = exmRegWrite_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            exmValid_q     <= 1'b0;
            exmAlu_q       <= '0;
            exmStoreData_q <= '0;
            exmFunct3_q    <= 3'b000;
            exmMemRead_q   <= 1'b0;
            exmMemWrite_q  <= 1'b0;
            exmRegWrite_q  <= 1'b0;
            exmRd_q        <= '0;
        end else if (!stall_out) begin
            exmValid_q     <= ex_valid & ~flush;
            exmAlu_q       <= ex_alu_out;
            exmStoreData_q <= ex_store_data;
            exmFunct3_q    <= ex_funct3;
            exmMemRead_q   <= ex_mem_read;
            exmMemWrite_q  <= ex_mem_write;
            exmRegWrite_q  <= ex_reg_write;
            exmRd_q        <= ex_rd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= MEM_IDLE;
            wbValid_q    <= 1'b0;
            wbResult_q   <= '0;
            wbRd_q       <= '0;
            wbRegWrite_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wbValid_q    <= wbValid_d;
            wbResult_q   <= wbResult_d;
            wbRd_q       <= wbRd_d;
            wbRegWrite_q <= wbRegWrite_d;
            misalign_q   <= misalign;
        end
    end

    assign wb_valid     = wbValid_q;
    assign wb_result    = wbResult_q;
    assign wb_rd        = wbRd_q;
    assign wb_reg_write = wbRegWrite_q;
    assign misalign_exc = misalign_q;

endmodule
